count_display_driver: RTL and testbench

- Downstream consumer of the 3-bit ripple counter.
- Samples the counter's asynchronous, glitch-prone ripple outputs into the system clock domain.
- Accepts a count value only after it has been stable for a programmable number of cycles.
- Drives a 7-segment digit and tracks count events: update strobe, wrap count, and non-sequential step errors.

---
 rtl/count_display_pkg.sv | 26 ++
 rtl/count_stability_filter.sv | 75 +++++++
 rtl/count_display_driver.sv | 100 ++++++++++
 tb/tb_count_display_driver.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_display_pkg.sv
// Shared types and constants for the ripple-count display path.
package count_display_pkg;

    localparam int SEG_W  = 7;
    localparam int CNT_W  = 3;
    localparam int STAB_W = 8;

    typedef enum logic [1:0] {
        WAIT_FIRST,
        SETTLE,
        LOCKED
    } filt_state_e;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG7_TABLE [0:7] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07
    };

    localparam logic [SEG_W-1:0] SEG_BLANK = '0;

    function automatic logic [SEG_W-1:0] seg7_encode(input logic [CNT_W-1:0] v,
                                                     input logic            active_low);
        return SEG7_TABLE[v] ^ {SEG_W{active_low}};
    endfunction

endpackage

// File: rtl/count_stability_filter.sv
// Synchronizes the raw ripple count and accepts a value once it has held
// for STABLE_CYCLES consecutive synchronized cycles.
module count_stability_filter
    import count_display_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             accept_o,
    output logic [CNT_W-1:0] accept_value_o
);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0]  s1_q;
    logic [CNT_W-1:0]  s2_q;
    logic [CNT_W-1:0]  cand_q, cand_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    filt_state_e       state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cand_q  <= '0;
            stab_q  <= '0;
            state_q <= WAIT_FIRST;
        end else begin
            s1_q    <= count_i;
            s2_q    <= s1_q;
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            state_q <= state_d;
        end
    end

    // A settled candidate equal to the held value simply returns to LOCKED.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        stab_d  = stab_q;
        unique case (state_q)
            WAIT_FIRST, SETTLE: begin
                if (s2_q != cand_q) begin
                    cand_d = s2_q;
                    stab_d = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = LOCKED;
                end else begin
                    stab_d = stab_q + 8'd1;
                end
            end
            LOCKED: begin
                if (s2_q != value_i) begin
                    cand_d  = s2_q;
                    stab_d  = '0;
                    state_d = SETTLE;
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    always_comb begin
        accept_o       = 1'b0;
        accept_value_o = cand_q;
        if (state_q != LOCKED && s2_q == cand_q && stab_q == STAB_LAST) begin
            accept_o = (state_q == WAIT_FIRST) || (cand_q != value_i);
        end
    end

endmodule

// File: rtl/count_display_driver.sv
// Drives a 7-segment digit from a filtered ripple count and tracks
// update, wrap and non-sequential step events.
module count_display_driver
    import count_display_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int WRAP_W         = 8,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic              input_clock1_1,
    input  logic              input_reset1_2,
    input  logic [CNT_W-1:0]  input_count_3,
    input  logic              input_clear_wraps_4,
    output logic [CNT_W-1:0]  output_value_5,
    output logic [SEG_W-1:0]  output_seg_6,
    output logic              output_valid_7,
    output logic              output_update_8,
    output logic              output_step_error_9,
    output logic [WRAP_W-1:0] output_wraps_10
);

    localparam logic             SEG_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [SEG_W-1:0] SEG_OFF  = SEG_BLANK ^ {SEG_W{SEG_INV}};
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    logic             accept;
    logic [CNT_W-1:0] accept_value;

    logic [CNT_W-1:0]  value_q, value_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              valid_q, valid_d;
    logic              update_q, update_d;
    logic              step_error_q, step_error_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic [CNT_W-1:0]  next_seq;
    logic              is_wrap;

    count_stability_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk_i          (input_clock1_1),
        .rst_i          (input_reset1_2),
        .count_i        (input_count_3),
        .value_i        (value_q),
        .accept_o       (accept),
        .accept_value_o (accept_value)
    );

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            value_q      <= '0;
            seg_q        <= SEG_OFF;
            valid_q      <= 1'b0;
            update_q     <= 1'b0;
            step_error_q <= 1'b0;
            wraps_q      <= '0;
        end else begin
            value_q      <= value_d;
            seg_q        <= seg_d;
            valid_q      <= valid_d;
            update_q     <= update_d;
            step_error_q <= step_error_d;
            wraps_q      <= wraps_d;
        end
    end

    always_comb begin
        next_seq     = value_q + 3'd1;
        is_wrap      = accept && valid_q && (value_q == 3'd7) && (accept_value == 3'd0);
        value_d      = value_q;
        seg_d        = seg_q;
        valid_d      = valid_q;
        update_d     = 1'b0;
        step_error_d = 1'b0;
        wraps_d      = wraps_q;

        if (accept) begin
            value_d      = accept_value;
            seg_d        = seg7_encode(accept_value, SEG_INV);
            valid_d      = 1'b1;
            update_d     = 1'b1;
            step_error_d = valid_q && (accept_value != next_seq);
        end

        // A wrap landing on the clearing edge survives as a single count.
        if (input_clear_wraps_4) begin
            wraps_d = is_wrap ? WRAP_ONE : '0;
        end else if (is_wrap && wraps_q != '1) begin
            wraps_d = wraps_q + WRAP_ONE;
        end
    end

    assign output_value_5      = value_q;
    assign output_seg_6        = seg_q;
    assign output_valid_7      = valid_q;
    assign output_update_8     = update_q;
    assign output_step_error_9 = step_error_q;
    assign output_wraps_10     = wraps_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver: two parameterizations share one stimulus
// stream and are compared every cycle against a run-length reference model.
module tb_count_display_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [2:0] cnt;

    logic [2:0] value_a, value_b;
    logic [6:0] seg_a, seg_b;
    logic       valid_a, valid_b;
    logic       upd_a, upd_b;
    logic       err_a, err_b;
    logic [7:0] wraps_a;
    logic [1:0] wraps_b;

    always #5 clk = ~clk;

    count_display_driver #(
        .STABLE_CYCLES(4), .WRAP_W(8), .SEG_ACTIVE_LOW(0)
    ) dut_a (
        .input_clock1_1      (clk),
        .input_reset1_2      (rst),
        .input_count_3       (cnt),
        .input_clear_wraps_4 (clr),
        .output_value_5      (value_a),
        .output_seg_6        (seg_a),
        .output_valid_7      (valid_a),
        .output_update_8     (upd_a),
        .output_step_error_9 (err_a),
        .output_wraps_10     (wraps_a)
    );

    count_display_driver #(
        .STABLE_CYCLES(2), .WRAP_W(2), .SEG_ACTIVE_LOW(1)
    ) dut_b (
        .input_clock1_1      (clk),
        .input_reset1_2      (rst),
        .input_count_3       (cnt),
        .input_clear_wraps_4 (clr),
        .output_value_5      (value_b),
        .output_seg_6        (seg_b),
        .output_valid_7      (valid_b),
        .output_update_8     (upd_b),
        .output_step_error_9 (err_b),
        .output_wraps_10     (wraps_b)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a value is accepted when the synchronized input has
    // shown it for STABLE_CYCLES+1 consecutive edges (reset counts as one).
    localparam int NM = 2;
    int P_S   [NM] = '{4, 2};
    int P_MAX [NM] = '{255, 3};
    int P_INV [NM] = '{0, 'h7F};
    int SEGT  [8]  = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07};

    int m_s1[NM], m_s2[NM], m_cur[NM], m_run[NM];
    int m_val[NM], m_valid[NM], m_upd[NM], m_err[NM], m_wraps[NM], m_seg[NM];

    function automatic void model_step(int k);
        int x, acc, wrap;
        if (rst) begin
            m_s1[k] = 0; m_s2[k] = 0; m_cur[k] = 0; m_run[k] = 1;
            m_val[k] = 0; m_valid[k] = 0; m_upd[k] = 0; m_err[k] = 0;
            m_wraps[k] = 0; m_seg[k] = P_INV[k];
            return;
        end
        x = m_s2[k];
        m_s2[k] = m_s1[k];
        m_s1[k] = int'(cnt);
        if (x == m_cur[k]) begin
            if (m_run[k] < 1000) m_run[k]++;
        end else begin
            m_cur[k] = x;
            m_run[k] = 1;
        end
        acc  = (m_run[k] == P_S[k] + 1) && (m_valid[k] == 0 || x != m_val[k]);
        wrap = acc && m_valid[k] != 0 && m_val[k] == 7 && x == 0;
        m_upd[k] = acc;
        m_err[k] = acc && m_valid[k] != 0 && x != (m_val[k] + 1) % 8;
        if (clr) m_wraps[k] = wrap ? 1 : 0;
        else if (wrap && m_wraps[k] < P_MAX[k]) m_wraps[k]++;
        if (acc) begin
            m_val[k]   = x;
            m_seg[k]   = SEGT[x] ^ P_INV[k];
            m_valid[k] = 1;
        end
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NM; k++) model_step(k);
    end

    int upd_a_n = 0;
    int err_a_n = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("a.value", value_a, m_val[0]);
            check_eq("a.seg",   seg_a,   m_seg[0]);
            check_eq("a.valid", valid_a, m_valid[0]);
            check_eq("a.update", upd_a,  m_upd[0]);
            check_eq("a.step_error", err_a, m_err[0]);
            check_eq("a.wraps", wraps_a, m_wraps[0]);
            check_eq("b.value", value_b, m_val[1]);
            check_eq("b.seg",   seg_b,   m_seg[1]);
            check_eq("b.valid", valid_b, m_valid[1]);
            check_eq("b.update", upd_b,  m_upd[1]);
            check_eq("b.step_error", err_b, m_err[1]);
            check_eq("b.wraps", wraps_b, m_wraps[1]);
            if (upd_a) upd_a_n++;
            if (err_a) err_a_n++;
        end
    end

    task automatic hold(input int v, input int n);
        cnt = 3'(v);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0, e0, prev, v, n;
        rst = 1'b1; clr = 1'b0; cnt = 3'd0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst.seg_a", seg_a, 7'h00);
        check_eq("rst.seg_b", seg_b, 7'h7F);
        check_eq("rst.valid_a", valid_a, 1'b0);

        rst = 1'b0;
        hold(0, 20);
        #1;
        check_eq("first.value", value_a, 3'd0);
        check_eq("first.seg", seg_a, 7'h3F);
        check_eq("first.pulses", upd_a_n, 1);
        check_eq("first.err", err_a_n, 0);

        for (int s = 1; s <= 8; s++) begin
            hold(s % 8, 20);
            #1;
            if (s == 7) check_eq("seq.seg7", seg_a, 7'h07);
        end
        check_eq("seq.pulses", upd_a_n, 9);
        check_eq("seq.err", err_a_n, 0);
        check_eq("seq.wraps", wraps_a, 8'd1);

        hold(3, 20);
        #1; p0 = upd_a_n; e0 = err_a_n;
        hold(7, 2);
        hold(4, 20);
        #1;
        check_eq("glitch.value", value_a, 3'd4);
        check_eq("glitch.pulses", upd_a_n - p0, 1);
        check_eq("glitch.err", err_a_n - e0, 0);

        hold(2, 20);
        #1; e0 = err_a_n;
        hold(5, 20);
        #1;
        check_eq("jump.value", value_a, 3'd5);
        check_eq("jump.seg", seg_a, 7'h6D);
        check_eq("jump.err", err_a_n - e0, 1);
        check_eq("jump.wraps", wraps_a, 8'd1);

        for (int lap = 0; lap < 5; lap++) begin
            for (int s = 1; s <= 8; s++) hold(s % 8, 8);
        end
        #1;
        check_eq("sat.wraps_b", wraps_b, 2'd3);
        check_eq("sat.wraps_a", wraps_a, 8'd6);

        for (int s = 1; s <= 7; s++) hold(s, 8);
        cnt = 3'd0;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check_eq("clrwrap.wraps_b", wraps_b, 2'd1);
        check_eq("clrwrap.wraps_a", wraps_a, 8'd1);
        check_eq("lowseg.seg_b", seg_b, 7'h40);

        hold(4, 20);
        cnt = 3'd5;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("midrst.update", upd_a, 1'b0);
        check_eq("midrst.valid", valid_a, 1'b0);
        check_eq("midrst.seg_a", seg_a, 7'h00);
        check_eq("midrst.seg_b", seg_b, 7'h7F);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1; p0 = upd_a_n; e0 = err_a_n;
        hold(5, 20);
        #1;
        check_eq("midrst.value", value_a, 3'd5);
        check_eq("midrst.pulses", upd_a_n - p0, 1);
        check_eq("midrst.err", err_a_n - e0, 0);

        prev = 5;
        repeat (400) begin
            v = ($urandom_range(0, 9) < 6) ? (prev + 1) % 8 : int'($urandom_range(0, 7));
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 24));
            clr = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 49) == 0);
            cnt = 3'(v);
            @(negedge clk);
            clr = 1'b0;
            rst = 1'b0;
            repeat (n - 1) @(negedge clk);
            prev = v;
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
